// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared widths and helpers for the FIFO read-side packer.
// Lane defaults, counter sizing and the contiguous byte-keep mask.
package fifo_stream_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PACK_DEF       = 4;
    localparam int unsigned MAX_PACK = 32;

    // Bits needed to index one lane of a PACK-lane word.
    function automatic int lane_idx_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    // Bits needed to count 0..PACK held lanes.
    function automatic int cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

    // Low n bits set: lane-valid mask for n bytes from lane 0.
    function automatic logic [MAX_PACK-1:0] keep_mask(
        input int unsigned n
    );
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PACK; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: byte assembly register for fifo_rd_packer.
// Holds up to PACK lanes, counts them and exposes the masked word.
module fifo_word_packer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PACK       = PACK_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cap,
    input  logic [DATA_WIDTH-1:0]        cap_data,
    input  logic                         take,
    output logic [cnt_w(PACK)-1:0]       asm_cnt,
    output logic [DATA_WIDTH*PACK-1:0]   asm_data,
    output logic [PACK-1:0]              part_keep
);

    localparam int CW = cnt_w(PACK);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_base;
    logic [DATA_WIDTH-1:0] lanes [PACK];

    // A take empties the register, so a same-cycle byte lands in lane 0.
    assign cnt_base = take ? '0 : cnt;
    assign asm_cnt  = cnt;

    // Lane counter: cleared by reset or take, bumped by each capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_base + CW'(cap);
        end
    end

    // Lane storage: the captured byte goes to the next free lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PACK; i++) begin
            if (cap && (cnt_base == CW'(i))) begin
                lanes[i] <= cap_data;
            end
        end
    end

    // Word view: lanes beyond the count read as zero.
    always_comb begin
        asm_data = '0;
        for (int i = 0; i < PACK; i++) begin
            if (CW'(i) < cnt) begin
                asm_data[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
            end
        end
    end

    assign part_keep = PACK'(keep_mask(32'(cnt)));

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains the async FIFO read port and packs bytes into words.
// Valid/ready master output with flush-driven partial words (keep + last).
module fifo_rd_packer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PACK       = PACK_DEF
) (
    input  logic                       rdclk,
    input  logic                       rdrst,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    output logic                       rd_en,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last
);

    localparam int OUT_WIDTH = DATA_WIDTH * PACK;
    localparam int CW        = cnt_w(PACK);
    localparam int CW1       = CW + 1;

    logic [CW-1:0]        asm_cnt;
    logic [OUT_WIDTH-1:0] asm_data;
    logic [PACK-1:0]      part_keep;

    logic inflight;
    logic flush_pend;
    logic out_free;
    logic asm_full;
    logic asm_empty;
    logic xfer_full;
    logic xfer_part;
    logic xfer;
    logic credit_ok;
    logic pend_done;

    assign out_free  = !m_valid || m_ready;
    assign asm_full  = (asm_cnt == CW'(PACK));
    assign asm_empty = (asm_cnt == '0);

    assign xfer_full = out_free && asm_full;
    assign xfer_part = out_free && flush_pend && !inflight
                     && !asm_empty && !asm_full;
    assign xfer      = xfer_full || xfer_part;

    // Held plus in-flight bytes must leave room for the next one.
    assign credit_ok = ({1'b0, asm_cnt} + {{CW{1'b0}}, inflight})
                     < CW1'(PACK);

    // Nothing left to emit: the flush completes without a word.
    assign pend_done = flush_pend && asm_empty && !inflight;

    assign rd_en = !rdrst && !fifo_empty && !flush_pend
                 && (credit_ok || xfer_full);

    fifo_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK)
    ) u_packer (
        .clk        (rdclk),
        .rst        (rdrst),
        .cap        (inflight),
        .cap_data   (fifo_dout),
        .take       (xfer),
        .asm_cnt    (asm_cnt),
        .asm_data   (asm_data),
        .part_keep  (part_keep)
    );

    // Read tracking and flush request latch.
    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (xfer_part || pend_done) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Output holding register: loads on transfer, empties on accept.
    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= asm_data;
            m_keep  <= xfer_full ? '1 : part_keep;
            m_last  <= xfer_part;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
